// File: rtl/timer_dev_if.sv
// timer_dev_if: bridge-to-device bus for the countdown timer.
// The bridge is the master; the timer is the slave responder.
interface timer_dev_if;
  logic [3:2]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic        WeDEV;
  logic [31:0] DEV_RD;
  logic        DEV_break;

  modport master (
    output DEV_Addr, DEV_WD, WeDEV,
    input  DEV_RD, DEV_break
  );

  modport slave (
    input  DEV_Addr, DEV_WD, WeDEV,
    output DEV_RD, DEV_break
  );
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer (CTRL / PRESET / COUNT).
// A 4-state FSM loads PRESET, counts down and raises an interrupt.
// Optional macro TIMER_PRESCALE_EN adds CTRL[7:4] as a 4-bit prescale
// divisor P; COUNT then advances only once every P+1 cycles.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input logic        clk,
  input logic        reset,
  timer_dev_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_00FF;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

  state_t      r_state;
  logic [31:0] r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;
`ifdef TIMER_PRESCALE_EN
  logic [3:0]  r_pre;
`endif

  logic w_ctrl_we;
  logic w_preset_we;
  logic w_tick;
  logic w_irq_set;

  // Decode writes, the count-enable tick and the interrupt-set condition.
  always_comb begin
    w_ctrl_we   = bus.WeDEV && (bus.DEV_Addr == 2'd0);
    w_preset_we = bus.WeDEV && (bus.DEV_Addr == 2'd1);
`ifdef TIMER_PRESCALE_EN
    w_tick      = (r_pre == r_ctrl[7:4]);
`else
    w_tick      = 1'b1;
`endif
    w_irq_set   = (r_state == S_CNT) && r_ctrl[0] && w_tick &&
                  (r_count <= 32'd1);
  end

  // Zero-latency read mux and interrupt output from registered state.
  always_comb begin
    case (bus.DEV_Addr)
      2'd0:    bus.DEV_RD = r_ctrl;
      2'd1:    bus.DEV_RD = r_preset;
      2'd2:    bus.DEV_RD = r_count;
      default: bus.DEV_RD = 32'd0;
    endcase
    bus.DEV_break = r_irq & r_ctrl[3];
  end

  // Timer FSM; CPU writes are applied last so they take priority,
  // except that an interrupt being raised this edge survives a CTRL write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 32'd0;
      r_preset <= PRESET_RST;
      r_count  <= 32'd0;
      r_irq    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      r_pre    <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ctrl[0]) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
`ifdef TIMER_PRESCALE_EN
          r_pre   <= 4'd0;
`endif
        end
        S_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
`ifdef TIMER_PRESCALE_EN
            r_pre <= 4'd0;
`endif
            if (r_count <= 32'd1) begin
              r_count <= 32'd0;
              r_irq   <= 1'b1;
              r_state <= S_INT;
            end else begin
              r_count <= r_count - 32'd1;
            end
          end else begin
`ifdef TIMER_PRESCALE_EN
            r_pre <= r_pre + 4'd1;
`endif
          end
        end
        S_INT: begin
          if (r_ctrl[2:1] == 2'b01) begin
            r_irq   <= 1'b0;
            r_state <= S_LOAD;
          end else begin
            r_ctrl[0] <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_preset_we) r_preset <= bus.DEV_WD;

      if (w_ctrl_we) begin
        r_ctrl <= bus.DEV_WD & CTRL_MASK;
        if (!w_irq_set) r_irq <= 1'b0;
`ifdef TIMER_PRESCALE_EN
        r_pre  <= 4'd0;
`endif
        // Disabling stops the timer in place: COUNT keeps its value.
        if (!bus.DEV_WD[0]) begin
          r_state <= S_IDLE;
          r_count <= r_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: randomized self-checking bench for timer_dev.
// Expected COUNT / DEV_break come from closed-form timing formulas.
module tb_timer_dev;
  localparam logic [31:0] TB_PRESET_RST = 32'h0000_00A5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  timer_dev_if bus ();

  timer_dev #(.PRESET_RST(TB_PRESET_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge, optionally carrying a write; returns 1 time unit after the edge.
  task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] d);
    bus.WeDEV    = we;
    bus.DEV_Addr = a;
    bus.DEV_WD   = d;
    @(posedge clk);
    #1;
    bus.WeDEV    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.DEV_Addr = a;
    #1;
    v = bus.DEV_RD;
  endtask

  // COUNT k edges after enabling: loaded with n at k=2, one step per edge after,
  // and in auto-reload the whole pattern repeats every n+2 edges.
  function automatic logic [31:0] exp_count(int k, int n, bit auto_m, logic [31:0] held);
    int j;
    if (k < 2) return held;
    j = k - 2;
    if (auto_m) j = j % (n + 2);
    return (j <= n) ? 32'(n - j) : 32'd0;
  endfunction

  function automatic logic exp_brk(int k, int n, bit auto_m, bit im);
    int j;
    if (k < 2) return 1'b0;
    j = k - 2;
    if (auto_m) return im && ((j % (n + 2)) == n);
    return im && (j >= n);
  endfunction

  initial begin
    logic [31:0] v;
    logic [31:0] held;
    logic [1:0]  mode;
    logic [31:0] ctrl_w;
    int n, abort_k, horizon, k_last;
    bit auto_m, im, aborted;

    bus.WeDEV = 1'b0; bus.DEV_Addr = 2'd0; bus.DEV_WD = 32'd0;
    reset = 1'b1;
    cyc(1'b0, 2'd0, 32'd0);
    cyc(1'b0, 2'd0, 32'd0);
    reset = 1'b0;

    // Reset values
    rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
    rd(2'd1, v); chk("rst_preset", v, TB_PRESET_RST);
    rd(2'd2, v); chk("rst_count", v, 32'd0);
    rd(2'd3, v); chk("rst_addr3", v, 32'd0);
    chk("rst_break", {31'd0, bus.DEV_break}, 32'd0);

    // Reserved CTRL bits read back as zero
    cyc(1'b1, 2'd0, 32'hFFFF_FFF6);
    rd(2'd0, v);
`ifdef TIMER_PRESCALE_EN
    chk("ctrl_mask", v, 32'h0000_00F6);
`else
    chk("ctrl_mask", v, 32'h0000_0006);
`endif
    cyc(1'b1, 2'd0, 32'd0);
    held = 32'd0;

    // Randomized runs: one-shot or auto-reload, random N, IM, optional abort
    for (int it = 0; it < 10; it++) begin
      n      = int'($urandom_range(1, 9));
      auto_m = 1'($urandom_range(0, 1));
      im     = 1'($urandom_range(0, 1));
      if (auto_m) mode = 2'b01;
      else begin
        case ($urandom_range(0, 2))
          0:       mode = 2'b00;
          1:       mode = 2'b10;
          default: mode = 2'b11;
        endcase
      end
      abort_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, n + 1)) : 1000;
      horizon = auto_m ? (2 + 4 * (n + 2) + 1) : (n + 5);
      ctrl_w  = {28'd0, im, mode, 1'b1};
      aborted = 1'b0;
      k_last  = 0;

      cyc(1'b1, 2'd1, 32'(n));
      cyc(1'b1, 2'd0, ctrl_w);
      rd(2'd2, v); chk("en_count", v, held);
      chk("en_break", {31'd0, bus.DEV_break}, 32'd0);

      for (int k = 1; k <= horizon && !aborted; k++) begin
        if (k == abort_k) begin
          cyc(1'b1, 2'd0, 32'd0);
          held = exp_count(k - 1, n, auto_m, held);
          rd(2'd2, v); chk("abort_count", v, held);
          rd(2'd0, v); chk("abort_ctrl", v, 32'd0);
          chk("abort_break", {31'd0, bus.DEV_break}, 32'd0);
          aborted = 1'b1;
        end else begin
          if (!auto_m && k >= 3 && $urandom_range(0, 2) == 0)
            cyc(1'b1, 2'($urandom_range(1, 3)), $urandom);
          else
            cyc(1'b0, 2'd0, 32'd0);
          rd(2'd2, v); chk("run_count", v, exp_count(k, n, auto_m, held));
          chk("run_break", {31'd0, bus.DEV_break}, {31'd0, exp_brk(k, n, auto_m, im)});
          k_last = k;
        end
      end

      if (!aborted) begin
        held = exp_count(k_last, n, auto_m, held);
        rd(2'd0, v);
        chk("end_ctrl", v, auto_m ? ctrl_w : {28'd0, im, mode, 1'b0});
        cyc(1'b1, 2'd0, 32'd0);
        rd(2'd2, v); chk("stop_count", v, held);
        chk("stop_break", {31'd0, bus.DEV_break}, 32'd0);
      end
    end

    // IM=0: interrupt stays hidden, then a CTRL write clears the pending flag
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) cyc(1'b0, 2'd0, 32'd0);
    rd(2'd2, v); chk("im0_count", v, 32'd0);
    chk("im0_break", {31'd0, bus.DEV_break}, 32'd0);
    cyc(1'b1, 2'd0, 32'h8);
    chk("im0_clr_break", {31'd0, bus.DEV_break}, 32'd0);

    // N=0 behaves like N=1: interrupt after E+3
    cyc(1'b1, 2'd1, 32'd0);
    cyc(1'b1, 2'd0, 32'h9);
    cyc(1'b0, 2'd0, 32'd0);
    cyc(1'b0, 2'd0, 32'd0);
    chk("n0_break_e2", {31'd0, bus.DEV_break}, 32'd0);
    cyc(1'b0, 2'd0, 32'd0);
    chk("n0_break_e3", {31'd0, bus.DEV_break}, 32'd1);
    cyc(1'b1, 2'd0, 32'd0);
    chk("n0_clear", {31'd0, bus.DEV_break}, 32'd0);

    // CTRL write on the very edge the interrupt is raised: the set wins
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) cyc(1'b0, 2'd0, 32'd0);
    cyc(1'b1, 2'd0, 32'h9);
    chk("setwins_break", {31'd0, bus.DEV_break}, 32'd1);
    rd(2'd2, v); chk("setwins_count", v, 32'd0);
    cyc(1'b1, 2'd0, 32'd0);

    // Synchronous reset mid-count (COUNT=7); counting must not resume
    cyc(1'b1, 2'd1, 32'd10);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) cyc(1'b0, 2'd0, 32'd0);
    rd(2'd2, v); chk("pre_rst_count", v, 32'd7);
    reset = 1'b1;
    cyc(1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    rd(2'd0, v); chk("mid_rst_ctrl", v, 32'd0);
    rd(2'd1, v); chk("mid_rst_preset", v, TB_PRESET_RST);
    rd(2'd2, v); chk("mid_rst_count", v, 32'd0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 32'd0);
    rd(2'd2, v); chk("mid_rst_hold", v, 32'd0);
    chk("mid_rst_break", {31'd0, bus.DEV_break}, 32'd0);

`ifdef TIMER_PRESCALE_EN
    // Prescale P=3: one step every 4 cycles, interrupt after E+2+N*(P+1)
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'h39);
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) cyc(1'b1, 2'd2, 32'h55);
      else        cyc(1'b0, 2'd0, 32'd0);
      if (k >= 2) begin
        rd(2'd2, v);
        chk("psc_count", v, (k - 2) / 4 >= 2 ? 32'd0 : 32'(2 - (k - 2) / 4));
        chk("psc_break", {31'd0, bus.DEV_break}, {31'd0, k >= 10});
      end
    end
    cyc(1'b1, 2'd0, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    if (n_fail != 0) $display("%0d error line(s) reported above", n_fail);
    $finish;
  end
endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer. It is the device-side responder on the CPU–device bridge interface.
- It sits at device slot 0 (CPU window 0x00007F00–0x00007F0F).
- The bridge decodes the slot and supplies `DEV_Addr[3:2]`, `DEV_WD` and the per-device write enable. This block returns read data and raises one interrupt line, which the bridge folds into `HWInt[2]`.
- Three word registers: CTRL, PRESET, COUNT. A 4-state FSM loads, counts down and signals an interrupt.

Parameters:
- `PRESET_RST`, 32'd0, reset value of the PRESET register.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `DEV_Addr`  input  [3:2]  word select from the bridge: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- `DEV_WD`  input  32  write data from the bridge.
- `WeDEV`  input  1  write enable, already qualified by the bridge's slot decode.
- `DEV_RD`  output  32  read data to the bridge.
- `DEV_break`  output  1  interrupt request to the bridge.

Behaviour:
- Reset: CTRL=0, PRESET=`PRESET_RST`, COUNT=0, irq_pending=0, state=IDLE. `DEV_break`=0. `DEV_RD` reflects the reset register values.
- CTRL fields:
  - bit0 EN.
  - bits[2:1] MODE: 00 one-shot; 01 auto-reload; 10/11 behave as 00.
  - bit3 IM, interrupt mask, 1=enabled.
  - bits[31:4] write-ignored, read 0.
- Read path: combinational with zero latency.
  - `DEV_RD` = CTRL, PRESET or COUNT per `DEV_Addr`.
  - Address 3 reads 0.
  - Reads have no side effects.
- Write path: on the rising edge when `WeDEV`=1.
  - Address 0: writes CTRL[3:0] and clears irq_pending.
  - Address 1: writes PRESET.
  - Addresses 2 and 3: ignored. COUNT is read-only.
- `DEV_break` = irq_pending & CTRL.IM. Both are registers, so the output is glitch-free.
- FSM, evaluated each edge after CPU-write priority is applied:
  - IDLE: if EN, go to LOAD. COUNT holds.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0: go to IDLE.
    - Else if COUNT<=1: COUNT<=0, irq_pending<=1, go to INT.
    - Else: COUNT<=COUNT-1.
  - INT:
    - MODE 01: irq_pending<=0; go to LOAD.
    - Other modes: CTRL.EN<=0; go to IDLE. irq_pending holds until the next CTRL write.
- Timing: EN written at edge E with PRESET=N (N≥1).
  - LOAD at E+1.
  - COUNT=N at E+2.
  - COUNT=0 and `DEV_break` high after edge E+N+2.
  - N=0 behaves like N=1: interrupt after E+3.
- Auto-reload period is N+2 cycles. `DEV_break` is high for exactly 1 cycle per period.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as INT's EN clear: the CPU write wins.
  - A CPU CTRL write with EN=0 in any state: next state IDLE, COUNT held, irq_pending cleared.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - A CTRL write in the same cycle irq_pending would be set: the set wins.
- Reset asserted mid-count: all state returns to reset values on that edge. Counting does not resume.
- COUNT never wraps. No decrement occurs below 0.

Optional Feature:
- Macro: `TIMER_PRESCALE_EN`.
- Enabled:
  - CTRL[7:4]=P becomes writable and readable.
  - An internal 4-bit prescaler, cleared in LOAD and on any CTRL write, makes CNT decrement (or take the COUNT<=1 exit) only on cycles where prescaler==P. The prescaler then wraps to 0.
  - Interrupt latency becomes E+2+N×(P+1).
  - P=0 is identical to the disabled behaviour.
- Disabled: CTRL[7:4] write-ignored and read 0. No prescaler logic.

Test Plan:
- Reset then read all addresses 0–3 → 0, `PRESET_RST`, 0, 0. `DEV_break`=0.
- PRESET=5, CTRL=0x9 (EN, mode 0, IM) at edge E → COUNT reads 5,4,3,2,1,0 at E+2..E+7. `DEV_break` rises after E+7 and stays high. CTRL.EN reads 0. Write CTRL=0 → `DEV_break` drops next cycle.
- PRESET=3, CTRL=0xB (auto-reload) → `DEV_break` 1-cycle pulses every 5 cycles, for ≥4 periods.
- CTRL=0x1 (IM=0), PRESET=2 → COUNT reaches 0 and `DEV_break` stays 0. Then write CTRL=0x8 → `DEV_break`=0, because the write cleared irq_pending.
- Mid-count (COUNT=7): write CTRL=0 → COUNT holds at 7, state IDLE. Re-enable → reloads PRESET. Separately, assert `reset` at COUNT=7 → all registers return to reset values.
- With `TIMER_PRESCALE_EN`: PRESET=2, CTRL=0x39 (P=3) → COUNT steps every 4 cycles. `DEV_break` after E+10. Write to address 2 → COUNT unaffected.
